// File: rtl/mem_bist_pkg.sv
// Shared constants for the memory BIST: state codes, phase and direction
// encodings, default background pattern and result counter width.
package mem_bist_pkg;

   // FSM state codes
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_W0   = 3'd1;
   localparam logic [2:0] S_M1   = 3'd2;
   localparam logic [2:0] S_M2   = 3'd3;
   localparam logic [2:0] S_M3   = 3'd4;
   localparam logic [2:0] S_FIN  = 3'd5;

   // Sub-phase inside a read/check element
   localparam logic PH_RD  = 1'b0;
   localparam logic PH_CHK = 1'b1;

   // Address walk direction
   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   localparam logic [7:0] DEFAULT_PATTERN = 8'h55;
   localparam int         ERR_CNT_W       = 8;

   // Only M2 walks downwards.
   function automatic logic elem_dir(input logic [2:0] st);
      return (st == S_M2) ? DIR_DN : DIR_UP;
   endfunction

endpackage

// File: rtl/mem_bist_addr_gen.sv
// Up/down address counter for the March elements. ld jumps to the first
// address of an element in direction ld_dir; step advances in direction dir
// and wraps naturally. last flags the terminal address for direction dir.
module mem_bist_addr_gen
   import mem_bist_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld,
   input  logic              ld_dir,
   input  logic              step,
   input  logic              dir,
   output logic [ADDR_W-1:0] adr,
   output logic              last
);

   // address register: load wins over step
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         adr <= '0;
      else if (ld)
         adr <= (ld_dir == DIR_UP) ? '0 : '1;
      else if (step)
         adr <= (dir == DIR_UP) ? adr + ADDR_W'(1) : adr - ADDR_W'(1);
   end

   assign last = (dir == DIR_UP) ? (adr == '1) : (adr == '0);

endmodule

// File: rtl/mem_bist.sv
// March-style BIST initiator for a single-port synchronous-read memory.
// Sequence: W0 up write P; M1 up read P / write ~P; M2 down read ~P /
// write P; M3 up read P. Compare is combinational in CHK, registered at its end.
// Optional build macro MEM_BIST_FAIL_STOP_EN: end the run at the first mismatch.
//
// state  | meaning
// IDLE   | waiting for start
// W0     | ascending write of background P, one cycle per address
// M1     | ascending RD / CHK(expect P, write ~P)
// M2     | descending RD / CHK(expect ~P, write P)
// M3     | ascending RD / CHK(expect P, no write)
// FIN    | done pulse, result published
module mem_bist
   import mem_bist_pkg::*;
#(
   parameter int                ADDR_W  = 4,
   parameter int                DATA_W  = 8,
   parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DEFAULT_PATTERN)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ADDR_W-1:0]    fail_adr,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [ADDR_W-1:0]    adr,
   output logic [DATA_W-1:0]    dat_w,
   output logic                 we,
   input  logic [DATA_W-1:0]    dat_r
);

   logic [2:0]           state;
   logic                 phase;
   logic                 last;
   logic                 ag_ld;
   logic                 ag_ld_dir;
   logic                 ag_step;
   logic                 ag_dir;
   logic                 chk;
   logic                 mism;
   logic                 stop;
   logic [DATA_W-1:0]    exp_dat;
   logic [ERR_CNT_W-1:0] err_nxt;

   mem_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .clk    (clk),
      .rst    (rst),
      .ld     (ag_ld),
      .ld_dir (ag_ld_dir),
      .step   (ag_step),
      .dir    (ag_dir),
      .adr    (adr),
      .last   (last)
   );

   assign ag_dir  = elem_dir(state);
   assign exp_dat = (state == S_M2) ? ~PATTERN : PATTERN;
   assign chk     = (phase == PH_CHK) &&
                    ((state == S_M1) || (state == S_M2) || (state == S_M3));
   assign mism    = chk && (dat_r != exp_dat);
   assign err_nxt = (mism && (err_cnt != '1)) ? err_cnt + ERR_CNT_W'(1) : err_cnt;

`ifdef MEM_BIST_FAIL_STOP_EN
   assign stop = mism;
`else
   assign stop = 1'b0;
`endif

   // address counter control: step within an element, reload at element change
   always_comb begin
      ag_ld     = 1'b0;
      ag_ld_dir = DIR_UP;
      ag_step   = 1'b0;
      case (state)
         S_IDLE: ag_ld = start;
         S_W0: begin
            if (last) ag_ld = 1'b1;
            else      ag_step = 1'b1;
         end
         S_M1, S_M2, S_M3: begin
            if (phase == PH_CHK) begin
               if (last && (state != S_M3)) begin
                  ag_ld     = 1'b1;
                  ag_ld_dir = (state == S_M1) ? DIR_DN : DIR_UP;
               end else begin
                  ag_step = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // sequencing FSM, memory write controls and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         phase    <= PH_RD;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         fail_adr <= '0;
         err_cnt  <= '0;
         dat_w    <= '0;
         we       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state    <= S_W0;
                  phase    <= PH_RD;
                  busy     <= 1'b1;
                  we       <= 1'b1;
                  dat_w    <= PATTERN;
                  err_cnt  <= '0;
                  fail_adr <= '0;
                  pass     <= 1'b0;
               end
            end
            S_W0: begin
               if (last) begin
                  state <= S_M1;
                  we    <= 1'b0;
               end
            end
            S_M1, S_M2, S_M3: begin
               if (phase == PH_RD) begin
                  phase <= PH_CHK;
                  we    <= (state != S_M3);
                  dat_w <= (state == S_M1) ? ~PATTERN : PATTERN;
               end else begin
                  phase   <= PH_RD;
                  we      <= 1'b0;
                  err_cnt <= err_nxt;
                  if (mism && (err_cnt == '0))
                     fail_adr <= adr;
                  if (stop || (last && (state == S_M3))) begin
                     state <= S_FIN;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_nxt == '0);
                  end else if (last) begin
                     state <= (state == S_M1) ? S_M2 : S_M3;
                  end
               end
            end
            S_FIN: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bist.sv
// Directed bench for mem_bist with a behavioural 16x8 memory and injectable faults.
module tb_mem_bist;

   logic       clk;
   logic       rst;
   logic       start;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] fail_adr;
   logic [7:0] err_cnt;
   logic [3:0] adr;
   logic [7:0] dat_w;
   logic       we;
   logic [7:0] dat_r;

   logic [7:0] mem [16];
   logic [7:0] rd_q;
   int         fault;

   int n_cmp;
   int n_err;

   logic [3:0] s_adr  [200];
   logic       s_we   [200];
   logic [7:0] s_dat  [200];
   logic       s_pass [200];

   int done_edge;
   int busy_cnt;
   int done_cnt;

`ifdef MEM_BIST_FAIL_STOP_EN
   localparam int EXP_S7_ERR  = 1;
   localparam int EXP_S7_EDGE = 32;
`else
   localparam int EXP_S7_ERR  = 3;
   localparam int EXP_S7_EDGE = 112;
`endif

   mem_bist dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .fail_adr (fail_adr),
      .err_cnt  (err_cnt),
      .adr      (adr),
      .dat_w    (dat_w),
      .we       (we),
      .dat_r    (dat_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory: fault 1 = addr 5 bit0 stuck-at-1, 2 = writes to 3 also hit 11,
   // 3 = addr 7 stuck at 00
   always @(posedge clk) begin
      if (we) begin
         case (fault)
            1:       mem[adr] <= (adr == 4'd5) ? (dat_w | 8'h01) : dat_w;
            3:       mem[adr] <= (adr == 4'd7) ? 8'h00 : dat_w;
            default: mem[adr] <= dat_w;
         endcase
         if (fault == 2 && adr == 4'd3)
            mem[11] <= dat_w;
      end
      rd_q <= mem[adr];
   end
   assign dat_r = rd_q;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // start is sampled at edge 0; i counts edges after it, sampled #1 later
   task automatic run_test(input bit poke, input bit hold);
      start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      done_edge = -1;
      busy_cnt  = 0;
      done_cnt  = 0;
      for (int i = 0; i < 200; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
         end
         if (poke) start = (i == 20) || (i == 50);
         s_adr[i]  = adr;
         s_we[i]   = we;
         s_dat[i]  = dat_w;
         s_pass[i] = pass;
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_edge = i;
            break;
         end
      end
      if (poke) start = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      fault = 0;
      rst   = 1'b1;
      start = 1'b0;
      #1;
      check("reset_outputs", 32'({busy, done, pass, fail_adr, err_cnt, adr, dat_w, we}), 32'h0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // fault-free run
      run_test(1'b0, 1'b0);
      check("clean_done_edge", done_edge, 112);
      check("clean_busy_cycles", busy_cnt, 112);
      check("clean_pass", pass, 1'b1);
      check("clean_err_cnt", err_cnt, 8'd0);
      check("clean_fail_adr", fail_adr, 4'd0);
      check("w0_first", {s_adr[0], s_we[0], s_dat[0]}, {4'd0, 1'b1, 8'h55});
      check("w0_second_adr", s_adr[1], 4'd1);
      check("m1_rd", {s_adr[16], s_we[16]}, {4'd0, 1'b0});
      check("m1_chk", {s_adr[17], s_we[17], s_dat[17]}, {4'd0, 1'b1, 8'hAA});
      check("m2_first_rd", {s_adr[48], s_we[48]}, {4'd15, 1'b0});
      check("m2_chk", {s_adr[49], s_we[49], s_dat[49]}, {4'd15, 1'b1, 8'h55});
      check("m3_chk", {s_adr[81], s_we[81]}, {4'd0, 1'b0});
      @(posedge clk); #1;
      check("done_one_cycle", {done, busy}, 2'b00);
      check("pass_held", pass, 1'b1);
      repeat (2) @(posedge clk); #1;

      // address 5 bit 0 stuck-at-1: only the M2 read of AA fails
      fault = 1;
      run_test(1'b0, 1'b0);
      check("sa1_pass", pass, 1'b0);
      check("sa1_fail_adr", fail_adr, 4'd5);
      check("sa1_err_cnt", err_cnt, 8'd1);
      repeat (2) @(posedge clk); #1;

      // writes to 3 also land in 11: M1 read of 11 sees AA
      fault = 2;
      run_test(1'b0, 1'b0);
      check("dec_pass", pass, 1'b0);
      check("dec_fail_adr", fail_adr, 4'd11);
      check("dec_err_cnt", err_cnt, 8'd1);
      repeat (2) @(posedge clk); #1;

      // start pokes mid-run are ignored
      fault = 0;
      run_test(1'b1, 1'b0);
      check("poke_done_edge", done_edge, 112);
      check("poke_done_cnt", done_cnt, 1);
      check("poke_pass", pass, 1'b1);
      repeat (2) @(posedge clk); #1;

      // start held across done: one-cycle gap then a new run clears pass
      run_test(1'b0, 1'b1);
      check("hold_first_pass", pass, 1'b1);
      @(posedge clk); #1;
      check("hold_gap", {busy, done}, 2'b00);
      run_test(1'b0, 1'b0);
      check("hold_second_busy", busy_cnt, 112);
      check("hold_pass_cleared", s_pass[0], 1'b0);
      check("hold_second_pass", pass, 1'b1);
      repeat (2) @(posedge clk); #1;

      // address 7 stuck at 00
      fault = 3;
      run_test(1'b0, 1'b0);
      check("s7_done_edge", done_edge, EXP_S7_EDGE);
      check("s7_pass", pass, 1'b0);
      check("s7_fail_adr", fail_adr, 4'd7);
      check("s7_err_cnt", err_cnt, EXP_S7_ERR);
      repeat (2) @(posedge clk); #1;

      // reset in the middle of M1
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (39) @(posedge clk);
      #1;
      check("mid_pre_err", err_cnt, 8'd1);
      rst = 1'b1;
      #1;
      check("mid_reset_outputs", 32'({busy, done, pass, fail_adr, err_cnt, adr, dat_w, we}), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      fault = 0;
      repeat (2) @(posedge clk); #1;
      run_test(1'b0, 1'b0);
      check("post_reset_done_edge", done_edge, 112);
      check("post_reset_pass", pass, 1'b1);
      check("post_reset_err", err_cnt, 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
